// File: rtl/adf4158_pkg.sv
// Shared definitions for the ADF4158 configuration controller.
//   state_e  : top-level sequencing states
//   NUM_REGS : number of synthesizer registers written (R7..R0)
//   WORD_W   : width of one serial configuration word
package adf4158_pkg;

    localparam int NUM_REGS = 8;
    localparam int WORD_W   = 32;
    localparam int IDX_W    = $clog2(NUM_REGS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PWRUP,
        S_LOAD,
        S_SHIFT,
        S_LATCH,
        S_LOCKWAIT,
        S_DONE
    } state_e;

endpackage

// File: rtl/adf4158_spi_shift.sv
// 32-bit MSB-first serial shifter with a divided serial clock.
//   clk_i, rst_n : system clock, synchronous active-low reset
//   clear        : abandon any word in flight, force sclk/data low
//   start        : load word (accepted when not busy); data shows bit 31 next cycle
//   word         : parallel word to send
//   busy         : a word is being shifted
//   done         : single-cycle strobe on the cycle of the final sclk fall
//   sclk, data   : serial bus; data changes only when sclk falls
module adf4158_spi_shift
    import adf4158_pkg::*;
#(
    parameter int SCLK_DIV = 2
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              start,
    input  logic [WORD_W-1:0] word,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              data
);

    localparam int DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int HALF_W = $clog2(2 * WORD_W);

    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic              busy_q, busy_d;
    logic              sclk_q, sclk_d;
    logic              data_q, data_d;
    logic              tick;

    // One half serial-clock period has elapsed.
    assign tick = busy_q && (div_q == DIV_W'(SCLK_DIV - 1));
    // 64th toggle is the fall after the 32nd rise.
    assign done = tick && (half_q == HALF_W'(2 * WORD_W - 1)) && !clear;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        shreg_d = shreg_q;
        div_d   = div_q;
        half_d  = half_q;
        busy_d  = busy_q;
        sclk_d  = sclk_q;
        data_d  = data_q;
        if (clear) begin
            busy_d = 1'b0;
            sclk_d = 1'b0;
            data_d = 1'b0;
            div_d  = '0;
            half_d = '0;
        end else if (start && !busy_q) begin
            shreg_d = word;
            data_d  = word[WORD_W-1];
            busy_d  = 1'b1;
            sclk_d  = 1'b0;
            div_d   = '0;
            half_d  = '0;
        end else if (busy_q) begin
            if (tick) begin
                div_d  = '0;
                half_d = half_q + HALF_W'(1);
                sclk_d = ~sclk_q;
                if (sclk_q) begin
                    // Falling edge: present the next bit.
                    shreg_d = shreg_q << 1;
                    data_d  = shreg_q[WORD_W-2];
                end
                if (done) begin
                    busy_d = 1'b0;
                    data_d = 1'b0;
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (!rst_n) begin
            shreg_q <= '0;
            div_q   <= '0;
            half_q  <= '0;
            busy_q  <= 1'b0;
            sclk_q  <= 1'b0;
            data_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            div_q   <= div_d;
            half_q  <= half_d;
            busy_q  <= busy_d;
            sclk_q  <= sclk_d;
            data_q  <= data_d;
        end
    end

    assign busy = busy_q;
    assign sclk = sclk_q;
    assign data = data_q;

endmodule

// File: rtl/adf4158_cfg.sv
// ADF4158 power-up and programming controller.
// Powers the chip (ce), waits PWRUP_CYCLES, writes R7..R0 over CLK/DATA/LE,
// then waits for digital lock detect on muxout and raises config_done.
//   clk_i, rst_n  : system clock, synchronous active-low reset
//   enable        : run configuration; low returns to power-down
//   muxout        : asynchronous lock detect from the chip
//   ce, le        : chip enable, load enable
//   sclk, data    : serial bus, data MSB first, sampled on sclk rise
//   txdata        : tied low
//   config_done   : all words written and lock seen
module adf4158_cfg
    import adf4158_pkg::*;
#(
    parameter int                SCLK_DIV     = 2,
    parameter int                PWRUP_CYCLES = 400,
    parameter int                LE_CYCLES    = 2,
    parameter logic [WORD_W-1:0] REG0         = 32'hF813_8000,
    parameter logic [WORD_W-1:0] REG1         = 32'h0000_0001,
    parameter logic [WORD_W-1:0] REG2         = 32'h0040_800A,
    parameter logic [WORD_W-1:0] REG3         = 32'h0000_0043,
    parameter logic [WORD_W-1:0] REG4         = 32'h0018_0104,
    parameter logic [WORD_W-1:0] REG5         = 32'h0000_0005,
    parameter logic [WORD_W-1:0] REG6         = 32'h0000_0006,
    parameter logic [WORD_W-1:0] REG7         = 32'h0000_0007
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic enable,
    input  logic muxout,
    output logic ce,
    output logic le,
    output logic sclk,
    output logic data,
    output logic txdata,
    output logic config_done
);

    if (REG0[2:0] != 3'd0 || REG1[2:0] != 3'd1 || REG2[2:0] != 3'd2 ||
        REG3[2:0] != 3'd3 || REG4[2:0] != 3'd4 || REG5[2:0] != 3'd5 ||
        REG6[2:0] != 3'd6 || REG7[2:0] != 3'd7) begin : g_bad_reg_addr
        $error("adf4158_cfg: REGn[2:0] must equal n");
    end
    if (SCLK_DIV < 1 || PWRUP_CYCLES < 1 || LE_CYCLES < 1) begin : g_bad_timing
        $error("adf4158_cfg: SCLK_DIV, PWRUP_CYCLES and LE_CYCLES must be >= 1");
    end

    localparam int LATCH_LEN = SCLK_DIV + LE_CYCLES;
    localparam int CNT_MAX   = (PWRUP_CYCLES > LATCH_LEN) ? PWRUP_CYCLES : LATCH_LEN;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               ce_q, ce_d;
    logic               le_q, le_d;
    logic               done_q, done_d;
    logic               lock_meta_q, lock_sync_q;
    logic               shift_start, shift_busy, shift_done;
    logic [WORD_W-1:0]  word_sel;

    always_comb begin
        word_sel = REG0;
        case (idx_q)
            3'd1:    word_sel = REG1;
            3'd2:    word_sel = REG2;
            3'd3:    word_sel = REG3;
            3'd4:    word_sel = REG4;
            3'd5:    word_sel = REG5;
            3'd6:    word_sel = REG6;
            3'd7:    word_sel = REG7;
            default: word_sel = REG0;
        endcase
    end

    // State register (plus counters and the lock synchronizer).
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            ce_q        <= 1'b0;
            le_q        <= 1'b0;
            done_q      <= 1'b0;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            ce_q        <= ce_d;
            le_q        <= le_d;
            done_q      <= done_d;
            lock_meta_q <= muxout;
            lock_sync_q <= lock_meta_q;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = IDX_W'(NUM_REGS - 1);
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_PWRUP;
                    cnt_d   = '0;
                end
                S_PWRUP: begin
                    if (cnt_q == CNT_W'(PWRUP_CYCLES - 1)) begin
                        state_d = S_LOAD;
                        cnt_d   = '0;
                        idx_d   = IDX_W'(NUM_REGS - 1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_LOAD: begin
                    if (!shift_busy) state_d = S_SHIFT;
                end
                S_SHIFT: begin
                    if (shift_done) begin
                        state_d = S_LATCH;
                        cnt_d   = '0;
                    end
                end
                S_LATCH: begin
                    // SCLK_DIV quiet cycles, then LE_CYCLES of le high.
                    if (cnt_q == CNT_W'(LATCH_LEN - 1)) begin
                        cnt_d = '0;
                        if (idx_q != '0) begin
                            idx_d   = idx_q - IDX_W'(1);
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_LOCKWAIT;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_LOCKWAIT: begin
                    if (lock_sync_q) state_d = S_DONE;
                end
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output logic, registered from the next state so pins change with the state.
    always_comb begin
        ce_d        = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        le_d        = (state_d == S_LATCH) && (cnt_d >= CNT_W'(SCLK_DIV)) &&
                      (cnt_d < CNT_W'(LATCH_LEN));
        shift_start = enable && (state_q == S_LOAD) && !shift_busy;
    end

    adf4158_spi_shift #(
        .SCLK_DIV (SCLK_DIV)
    ) u_shift (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .clear (!enable),
        .start (shift_start),
        .word  (word_sel),
        .busy  (shift_busy),
        .done  (shift_done),
        .sclk  (sclk),
        .data  (data)
    );

    assign ce          = ce_q;
    assign le          = le_q;
    assign config_done = done_q;
    assign txdata      = 1'b0;

endmodule

// File: tb/tb_adf4158_cfg.sv
module tb_adf4158_cfg;

    localparam int SCLK_DIV     = 2;
    localparam int PWRUP_CYCLES = 400;
    localparam int LE_CYCLES    = 2;

    logic clk_i = 1'b0;
    logic rst_n, enable, muxout;
    logic ce, le, sclk, data, txdata, config_done;

    adf4158_cfg #(
        .SCLK_DIV     (SCLK_DIV),
        .PWRUP_CYCLES (PWRUP_CYCLES),
        .LE_CYCLES    (LE_CYCLES)
    ) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .enable      (enable),
        .muxout      (muxout),
        .ce          (ce),
        .le          (le),
        .sclk        (sclk),
        .data        (data),
        .txdata      (txdata),
        .config_done (config_done)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard of words expected on the bus, in order.
    logic [31:0] exp_q[$];

    task automatic push_seq(input int count);
        logic [31:0] seq [8];
        seq = '{32'h0000_0007, 32'h0000_0006, 32'h0000_0005, 32'h0018_0104,
                32'h0000_0043, 32'h0040_800A, 32'h0000_0001, 32'hF813_8000};
        for (int i = 0; i < count; i++) exp_q.push_back(seq[i]);
    endtask

    // Bus monitor: decodes words on sclk rise, compares on each le rise.
    logic [31:0] acc = '0;
    int nbits = 0, le_rises = 0, le_len = 0;
    int first_rise = 0, last_rise = 0, last_fall = 0, period_meas = 0;
    int tx_bad = 0, data_bad = 0, sclk_le_bad = 0, period_bad = 0;
    logic sclk_p = 1'b0, data_p = 1'b0, le_p = 1'b0;

    always @(negedge clk_i) begin
        logic [31:0] exp_w;
        if (txdata !== 1'b0) tx_bad++;
        if (ce !== 1'b1) nbits = 0;
        if (sclk === 1'b1 && sclk_p === 1'b0) begin
            if (le) sclk_le_bad++;
            if (data !== data_p) data_bad++;
            acc = {acc[30:0], data};
            if (nbits == 0) first_rise = cyc;
            else begin
                if (nbits == 1) period_meas = cyc - last_rise;
                if (cyc - last_rise != 2 * SCLK_DIV) period_bad++;
            end
            last_rise = cyc;
            nbits++;
        end
        if (sclk === 1'b0 && sclk_p === 1'b1) begin
            if (le) sclk_le_bad++;
            last_fall = cyc;
        end
        if (le === 1'b1 && le_p === 1'b0) begin
            le_rises++;
            le_len = 1;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_le: word 0x%08h latched with nothing expected", acc);
            end else begin
                exp_w = exp_q.pop_front();
                check("bus_word", acc, exp_w);
                check("bus_bits", nbits, 32);
                // SHIFT is 64*SCLK_DIV cycles with a leading low half-period.
                check("word_span", last_fall - first_rise, 63 * SCLK_DIV);
            end
            nbits = 0;
        end else if (le === 1'b1) begin
            le_len++;
        end
        if (le === 1'b0 && le_p === 1'b1) check("le_width", le_len, LE_CYCLES);
        sclk_p = sclk;
        data_p = data;
        le_p   = le;
    end

    // Called at the negedge where ce was first seen high.
    task automatic time_first_sclk(input string name);
        int c0, k;
        c0 = cyc;
        k  = 0;
        while (sclk !== 1'b1 && k < 2000) begin
            @(negedge clk_i);
            k++;
        end
        // SHIFT starts PWRUP_CYCLES+1 cycles after ce, sclk then stays low SCLK_DIV cycles.
        check(name, cyc - c0, PWRUP_CYCLES + 1 + SCLK_DIV);
    endtask

    task automatic enable_and_time(input string name);
        enable = 1'b1;
        @(negedge clk_i);
        check({name, "_ce_rise"}, ce, 1);
        time_first_sclk({name, "_first_sclk"});
    endtask

    task automatic wait_words(input string name, input int target);
        int k;
        k = 0;
        while (le_rises < target && k < 3000) begin
            @(negedge clk_i);
            k++;
        end
        check({name, "_le_count"}, le_rises, target);
    endtask

    initial begin
        int bad, lat, base, k;
        rst_n  = 1'b0;
        enable = 1'b0;
        muxout = 1'b0;
        repeat (3) @(negedge clk_i);
        check("reset_outputs", {26'd0, ce, le, sclk, data, txdata, config_done}, 0);
        rst_n = 1'b1;
        @(negedge clk_i);
        check("idle_ce_low", ce, 0);

        // Full sequence with no lock.
        push_seq(8);
        enable_and_time("t1");
        wait_words("t1", 8);
        bad = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (config_done !== 1'b0) bad++;
        end
        check("t1_done_low", bad, 0);
        check("t1_queue_empty", exp_q.size(), 0);
        check("sclk_period", period_meas, 2 * SCLK_DIV);

        // Lock arrives: config_done after the 2-flop sync plus state change.
        muxout = 1'b1;
        lat = 0;
        while (config_done !== 1'b1 && lat < 10) begin
            @(negedge clk_i);
            lat++;
        end
        check("lock_latency", lat, 3);
        muxout = 1'b0;
        repeat (10) @(negedge clk_i);
        check("done_sticky", {28'd0, config_done, ce, sclk, le}, 32'hC);

        // Disable from DONE, then abort in the middle of R4.
        enable = 1'b0;
        @(negedge clk_i);
        check("disable_outputs", {28'd0, ce, le, sclk, config_done}, 0);
        repeat (5) @(negedge clk_i);
        base = le_rises;
        push_seq(3);
        enable_and_time("t3a");
        wait_words("t3a", base + 3);
        repeat (40) @(negedge clk_i);
        check("t3_mid_r4_sclk_active", ce, 1);
        enable = 1'b0;
        @(negedge clk_i);
        check("abort_outputs", {28'd0, ce, le, sclk, data}, 0);
        check("t3_queue_empty", exp_q.size(), 0);
        repeat (5) @(negedge clk_i);
        push_seq(8);
        enable_and_time("t3b");
        wait_words("t3b", base + 11);
        repeat (10) @(negedge clk_i);
        check("t3b_done_low", config_done, 0);

        // Reset during the quiet part of R6's LATCH.
        enable = 1'b0;
        repeat (2) @(negedge clk_i);
        base = le_rises;
        push_seq(1);
        enable_and_time("t4a");
        wait_words("t4a", base + 1);
        k = 0;
        while (le !== 1'b0 && k < 20) begin
            @(negedge clk_i);
            k++;
        end
        // Now in LOAD: 1 cycle LOAD + 128 cycles SHIFT reaches the start of LATCH.
        repeat (1 + 64 * SCLK_DIV) @(negedge clk_i);
        check("t4_in_latch", {29'd0, ce, le, sclk}, 32'h4);
        rst_n = 1'b0;
        @(negedge clk_i);
        check("latch_reset_outputs", {26'd0, ce, le, sclk, data, txdata, config_done}, 0);
        check("t4_no_le_pulse", le_rises, base + 1);
        rst_n = 1'b1;
        push_seq(8);
        @(negedge clk_i);
        check("t4b_ce_rise", ce, 1);
        time_first_sclk("t4b_first_sclk");
        wait_words("t4b", base + 9);
        repeat (10) @(negedge clk_i);
        check("t4_queue_empty", exp_q.size(), 0);

        check("le_total", le_rises, 28);
        check("txdata_low", tx_bad, 0);
        check("data_stable_on_rise", data_bad, 0);
        check("sclk_quiet_while_le", sclk_le_bad, 0);
        check("sclk_period_all", period_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
